// File: rtl/wire_pipe_array.sv
// -----------------------------------------------------------------------------
// wire_pipe_array
//
// Carries CHANNELS lanes of WIDTH bits through DEPTH elastic register stages
// that share one valid/ready handshake. Lanes can be masked per beat, and the
// number of occupied stages is reported on a registered occupancy output.
//
// Ports
//   clk        in   1               rising-edge clock
//   rst        in   1               synchronous, active-high reset
//   in_valid   in   1               producer offers a beat
//   in_ready   out  1               a beat is accepted this cycle if in_valid=1
//   in_data    in   CHANNELS*WIDTH  lane-packed input; lane 0 in the LSBs
//   chan_en    in   CHANNELS        per-lane enable, captured with the beat
//   out_valid  out  1               out_data holds a valid beat
//   out_ready  in   1               consumer takes the beat this cycle
//   out_data   out  CHANNELS*WIDTH  lane-packed output
//   occupancy  out  $clog2(DEPTH+1) number of valid stages (0..DEPTH)
// -----------------------------------------------------------------------------
module wire_pipe_array #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  input  logic [CHANNELS-1:0]           chan_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int CW    = CHANNELS * WIDTH;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [CW-1:0]    dat_q [DEPTH];
  logic [CW-1:0]    dat_d [DEPTH];
  logic [DEPTH-1:0] load;
  logic [CW-1:0]    masked;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             accept;
  logic             emit;

  // Lane masking: a disabled lane is captured as zero, so the mask travels
  // with the beat and later chan_en changes cannot touch it.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    assign masked[gi*WIDTH +: WIDTH] = chan_en[gi] ? in_data[gi*WIDTH +: WIDTH] : '0;
  end

  // Load conditions, resolved from the output end backwards. A stage can
  // load when it is empty or when whatever is ahead of it can take its
  // contents this cycle. This makes in_ready combinational from out_ready,
  // which is what lets a full pipe accept and emit in the same cycle.
  always_comb begin
    logic ahead;
    ahead = out_ready;
    load  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      load[k] = !vld_q[k] || ahead;
      ahead   = load[k];
    end
  end

  assign in_ready = !rst && load[0];
  assign accept   = in_valid && in_ready;
  assign emit     = vld_q[DEPTH-1] && out_ready;

  // Per-stage next state. Stage 0 is fed from the input port, every other
  // stage from the stage behind it. Data only moves when the source holds a
  // valid beat, so empty stages keep their last contents.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic          src_vld;
    logic [CW-1:0] src_dat;
    if (gi == 0) begin : g_head
      assign src_vld = accept;
      assign src_dat = masked;
    end else begin : g_body
      assign src_vld = vld_q[gi-1];
      assign src_dat = dat_q[gi-1];
    end
    assign vld_d[gi] = load[gi] ? src_vld : vld_q[gi];
    assign dat_d[gi] = (load[gi] && src_vld) ? src_dat : dat_q[gi];
  end

  // Occupancy tracks the handshakes directly rather than counting bits.
  always_comb begin
    occ_d = occ_q;
    case ({accept, emit})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      for (int k = 0; k < DEPTH; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_wire_pipe_array.sv
// -----------------------------------------------------------------------------
// tb_wire_pipe_array
//
// Scoreboard bench for wire_pipe_array (CHANNELS=4, WIDTH=16, DEPTH=3).
// The driver pushes the masked expected beat whenever a handshake is seen;
// an independent monitor pops and compares whenever a beat leaves, and keeps
// its own running count of beats in flight to check occupancy.
// -----------------------------------------------------------------------------
module tb_wire_pipe_array;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int D  = 3;
  localparam int CW = CH * W;
  localparam int OW = $clog2(D + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_data;
  logic [CH-1:0] chan_en;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_data;
  logic [OW-1:0] occupancy;

  typedef struct {
    logic [CW-1:0] data;
    int            acc_cyc;
    bit            exact;
  } exp_t;

  exp_t sb[$];
  int   total     = 0;
  int   bad       = 0;
  int   cyc       = 0;
  int   exp_occ   = 0;
  bit   lat_exact = 0;

  wire_pipe_array #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .chan_en   (chan_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference lane mask: disabled lanes read as zero.
  function automatic logic [CW-1:0] mask_beat(input logic [CW-1:0] d, input logic [CH-1:0] en);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      if (en[i]) r[i*W +: W] = d[i*W +: W];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge
  // and the handshake is observed on the falling edge.
  task automatic step(input logic v, input logic [CW-1:0] d, input logic [CH-1:0] en,
                      input logic ordy, output bit acc);
    exp_t e;
    in_valid  = v;
    in_data   = d;
    chan_en   = en;
    out_ready = ordy;
    @(negedge clk);
    acc = in_valid && in_ready && !rst;
    if (acc) begin
      e.data    = mask_beat(d, en);
      e.acc_cyc = cyc;
      e.exact   = lat_exact;
      sb.push_back(e);
      $display("beat in   data=%h en=%b", d, en);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] d, input logic [CH-1:0] en, input logic ordy);
    bit acc;
    acc = 0;
    for (int t = 0; t < 40 && !acc; t++) step(1'b1, d, en, ordy, acc);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send timeout: beat %h never accepted", d);
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    bit acc;
    for (int t = 0; t < n; t++) step(1'b0, {$urandom, $urandom}, 4'(($urandom)), ordy, acc);
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    sb.delete();
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  // Monitor: independent of the driver apart from the shared expectation queue.
  always @(negedge clk) begin
    exp_t h;
    bit   acc;
    bit   emt;
    if (rst) begin
      chk("in_ready during reset", 64'(in_ready), 64'd0);
      exp_occ = 0;
    end else begin
      chk("occupancy", 64'(occupancy), 64'(exp_occ));
      if (exp_occ == 0) chk("out_valid when empty", 64'(out_valid), 64'd0);
      if (exp_occ == D) chk("in_ready when full", 64'(in_ready), 64'(out_ready));
      acc = in_valid && in_ready;
      emt = out_valid && out_ready;
      if (emt) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected beat: got %h want none", out_data);
        end else begin
          h = sb.pop_front();
          chk("out_data", out_data, h.data);
          if (h.exact) chk("latency", 64'(cyc - h.acc_cyc), 64'(D));
          $display("beat out  data=%h latency=%0d", out_data, cyc - h.acc_cyc);
        end
      end else if (out_valid && sb.size() > 0) begin
        chk("stalled out_data", out_data, sb[0].data);
      end
      if (acc && !emt) exp_occ++;
      else if (!acc && emt) exp_occ--;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit            acc;
    int            n;
    logic [CW-1:0] beats [5];

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom};
    chan_en   = 4'hF;
    out_ready = 1'b1;

    // 1. reset with beats offered
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", out_data, 64'd0);
    chk("reset occupancy", 64'(occupancy), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("in_ready after reset", 64'(in_ready), 64'd1);

    // 2. streaming with no backpressure: exact latency, one per cycle
    lat_exact = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 64'h0001_0002_0003_0004 + 64'(i), 4'hF, 1'b1, acc);
      n += int'(acc);
    end
    chk("t2 accepts", 64'(n), 64'd8);
    idle(6, 1'b1);
    lat_exact = 0;
    chk("t2 drained", 64'(occupancy), 64'd0);

    // 3. backpressure: only DEPTH beats fit
    for (int i = 0; i < 5; i++) beats[i] = {$urandom, $urandom};
    n = 0;
    for (int t = 0; t < 6; t++) begin
      step(1'b1, beats[n], 4'hF, 1'b0, acc);
      n += int'(acc);
    end
    chk("t3 accepted while stalled", 64'(n), 64'd3);
    chk("t3 occupancy full", 64'(occupancy), 64'd3);
    chk("t3 in_ready full", 64'(in_ready), 64'd0);
    for (int t = 0; t < 20 && n < 5; t++) begin
      step(1'b1, beats[n], 4'hF, 1'b1, acc);
      n += int'(acc);
    end
    chk("t3 total accepted", 64'(n), 64'd5);
    idle(6, 1'b1);
    chk("t3 drained", 64'(occupancy), 64'd0);

    // 4. lane masking, chan_en toggles while the beat is in flight
    send(64'hAAAA_BBBB_CCCC_DDDD, 4'b0101, 1'b1);
    for (int t = 0; t < 6; t++) step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'(t), 1'b1, acc);

    // 5. full pipe, simultaneous accept and emit
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 4'hF, 1'b0);
    chk("t5 occupancy before", 64'(occupancy), 64'd3);
    lat_exact = 1;
    n = 0;
    for (int t = 0; t < 4; t++) begin
      step(1'b1, {$urandom, $urandom}, 4'hF, 1'b1, acc);
      n += int'(acc);
      chk("t5 occupancy steady", 64'(occupancy), 64'd3);
    end
    chk("t5 accepts", 64'(n), 64'd4);
    idle(6, 1'b1);
    lat_exact = 0;

    // 6. reset with two beats in flight
    send(64'h1111_2222_3333_4444, 4'hF, 1'b0);
    send(64'h5555_6666_7777_8888, 4'hF, 1'b0);
    chk("t6 occupancy before", 64'(occupancy), 64'd2);
    do_reset(1);
    chk("t6 occupancy after", 64'(occupancy), 64'd0);
    chk("t6 out_valid after", 64'(out_valid), 64'd0);
    chk("t6 out_data after", out_data, 64'd0);
    lat_exact = 1;
    send(64'h9999_AAAA_BBBB_CCCC, 4'hF, 1'b1);
    idle(6, 1'b1);
    lat_exact = 0;

    // Randomised traffic with occasional resets
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom),
             1'($urandom_range(0, 3) != 0), acc);
      end
    end
    idle(10, 1'b1);
    chk("final scoreboard empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
